// File: rtl/store_checker.sv
// rtl/store_checker.sv - end-of-program store monitor for the core data-memory port
// Optional timeout logic: STORE_CHECK_TIMEOUT_EN
module store_checker #(
  parameter int unsigned       WIDTH     = 32,
  parameter logic [WIDTH-1:0]  PASS_ADR  = 100,
  parameter logic [WIDTH-1:0]  PASS_DATA = 25,
  parameter logic [WIDTH-1:0]  SCR_BASE  = 96,
  parameter logic [WIDTH-1:0]  SCR_SIZE  = 4,
  parameter int unsigned       TIMEOUT   = 1024,
  parameter int unsigned       CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             MemWrite,
  input  logic [WIDTH-1:0] DataAdr,
  input  logic [WIDTH-1:0] WriteData,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic [1:0]       fail_code,
  output logic [WIDTH-1:0] fail_adr,
  output logic [WIDTH-1:0] fail_data,
  output logic [CNT_W-1:0] write_count,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_PASS = 2'd2,
    S_FAIL = 2'd3
  } state_e;

  localparam logic [1:0] CODE_NONE = 2'd0;
  localparam logic [1:0] CODE_ADR  = 2'd1;
  localparam logic [1:0] CODE_DATA = 2'd2;
  localparam logic [1:0] CODE_TO   = 2'd3;

  // One bit wider than the bus so a window ending at the top of memory cannot wrap.
  localparam logic [WIDTH:0] SCR_END = {1'b0, SCR_BASE} + {1'b0, SCR_SIZE};

  state_e           state_q, state_d;
  logic [1:0]       fail_code_q, fail_code_d;
  logic [WIDTH-1:0] fail_adr_q, fail_adr_d;
  logic [WIDTH-1:0] fail_data_q, fail_data_d;
  logic [CNT_W-1:0] write_count_q, write_count_d;
  logic [CNT_W-1:0] cycle_count_q, cycle_count_d;

  logic             in_window;
  logic             is_pass_adr;
  logic             timeout_hit;
  logic [CNT_W-1:0] cycle_inc;
  logic [CNT_W-1:0] write_inc;

  // Address classification; only meaningful while MemWrite is high.
  always_comb begin
    in_window   = ({1'b0, DataAdr} >= {1'b0, SCR_BASE}) && ({1'b0, DataAdr} < SCR_END);
    is_pass_adr = (DataAdr == PASS_ADR);
  end

  // Saturating increments of both counters.
  always_comb begin
    cycle_inc = (cycle_count_q == {CNT_W{1'b1}}) ? cycle_count_q : cycle_count_q + 1'b1;
    write_inc = (write_count_q == {CNT_W{1'b1}}) ? write_count_q : write_count_q + 1'b1;
  end

`ifdef STORE_CHECK_TIMEOUT_EN
  localparam int unsigned TO_LAST = TIMEOUT - 1;
  // Fires on the edge where the RUN cycle count would reach TIMEOUT.
  always_comb begin
    timeout_hit = (32'(cycle_count_q) >= TO_LAST);
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
  // Without the timeout option RUN waits indefinitely.
  always_comb begin
    timeout_hit = 1'b0;
  end
`endif

  // Next-state and capture logic, RUN rules evaluated in priority order.
  always_comb begin
    state_d       = state_q;
    fail_code_d   = fail_code_q;
    fail_adr_d    = fail_adr_q;
    fail_data_d   = fail_data_q;
    write_count_d = write_count_q;
    cycle_count_d = cycle_count_q;
    if (!en) begin
      state_d       = S_IDLE;
      fail_code_d   = CODE_NONE;
      fail_adr_d    = '0;
      fail_data_d   = '0;
      write_count_d = '0;
      cycle_count_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // The arming edge never looks at the store bus.
          state_d       = S_RUN;
          write_count_d = '0;
          cycle_count_d = '0;
        end
        S_RUN: begin
          cycle_count_d = cycle_inc;
          if (MemWrite) begin
            write_count_d = write_inc;
          end
          if (MemWrite && is_pass_adr) begin
            if (WriteData == PASS_DATA) begin
              state_d = S_PASS;
            end else begin
              state_d     = S_FAIL;
              fail_code_d = CODE_DATA;
              fail_adr_d  = DataAdr;
              fail_data_d = WriteData;
            end
          end else if (MemWrite && !in_window) begin
            state_d     = S_FAIL;
            fail_code_d = CODE_ADR;
            fail_adr_d  = DataAdr;
            fail_data_d = WriteData;
          end else if (timeout_hit) begin
            state_d     = S_FAIL;
            fail_code_d = CODE_TO;
          end
        end
        default: begin
          // PASS and FAIL are sticky until en drops.
          state_d = state_q;
        end
      endcase
    end
  end

  // State and capture registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      fail_code_q   <= CODE_NONE;
      fail_adr_q    <= '0;
      fail_data_q   <= '0;
      write_count_q <= '0;
      cycle_count_q <= '0;
    end else begin
      state_q       <= state_d;
      fail_code_q   <= fail_code_d;
      fail_adr_q    <= fail_adr_d;
      fail_data_q   <= fail_data_d;
      write_count_q <= write_count_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  // Verdict outputs decode directly from the registered state.
  always_comb begin
    done        = (state_q == S_PASS) || (state_q == S_FAIL);
    pass        = (state_q == S_PASS);
    fail        = (state_q == S_FAIL);
    fail_code   = fail_code_q;
    fail_adr    = fail_adr_q;
    fail_data   = fail_data_q;
    write_count = write_count_q;
    cycle_count = cycle_count_q;
  end

endmodule

// File: tb/tb_store_checker.sv
// tb/tb_store_checker.sv - randomized self-checking bench for store_checker
module tb_store_checker;

  localparam int  PADR  = 100;
  localparam int  PDATA = 25;
  localparam int  SBASE = 96;
  localparam int  SSIZE = 4;
  localparam int  TO    = 64;
  localparam int  CMAX  = 65535;
`ifdef STORE_CHECK_TIMEOUT_EN
  localparam bit  TO_EN = 1'b1;
`else
  localparam bit  TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] DataAdr = '0;
  logic [31:0] WriteData = '0;
  logic        done, pass, fail;
  logic [1:0]  fail_code;
  logic [31:0] fail_adr, fail_data;
  logic [15:0] write_count, cycle_count;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: verdict 0 idle, 1 running, 2 passed, 3 failed.
  int          m_st;
  int          m_code;
  logic [31:0] m_adr, m_data;
  int          m_wc, m_cc;

  always #5 clk = ~clk;

  store_checker #(
    .WIDTH(32), .PASS_ADR(32'd100), .PASS_DATA(32'd25),
    .SCR_BASE(32'd96), .SCR_SIZE(32'd4), .TIMEOUT(TO), .CNT_W(16)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .MemWrite(MemWrite),
    .DataAdr(DataAdr), .WriteData(WriteData),
    .done(done), .pass(pass), .fail(fail), .fail_code(fail_code),
    .fail_adr(fail_adr), .fail_data(fail_data),
    .write_count(write_count), .cycle_count(cycle_count)
  );

  wire [100:0] obs = {done, pass, fail, fail_code, fail_adr, fail_data, write_count, cycle_count};

  function automatic logic [100:0] exp_vec();
    return {(m_st == 2 || m_st == 3), (m_st == 2), (m_st == 3), 2'(m_code),
            m_adr, m_data, 16'(m_wc), 16'(m_cc)};
  endfunction

  task automatic model_clear();
    m_st = 0; m_code = 0; m_adr = '0; m_data = '0; m_wc = 0; m_cc = 0;
  endtask

  task automatic model_fail(input int code, input logic [31:0] a, input logic [31:0] d);
    m_st = 3; m_code = code; m_adr = a; m_data = d;
  endtask

  task automatic model_edge(input logic e, input logic mw, input logic [31:0] a, input logic [31:0] d);
    longint la;
    if (e !== 1'b1) begin
      model_clear();
    end else if (m_st == 0) begin
      m_st = 1; m_wc = 0; m_cc = 0;
    end else if (m_st == 1) begin
      if (m_cc < CMAX) m_cc++;
      if (mw === 1'b1) begin
        if (m_wc < CMAX) m_wc++;
        la = longint'(a);
        if (la == PADR) begin
          if (longint'(d) == PDATA) m_st = 2;
          else model_fail(2, a, d);
        end else if (la < SBASE || la >= SBASE + SSIZE) begin
          model_fail(1, a, d);
        end else if (TO_EN && m_cc >= TO) begin
          model_fail(3, '0, '0);
        end
      end else if (TO_EN && m_cc >= TO) begin
        model_fail(3, '0, '0);
      end
    end
  endtask

  // Present inputs from a falling edge, take one rising edge, return at the next falling edge.
  task automatic drive(input logic e, input logic mw, input logic [31:0] a, input logic [31:0] d);
    en = e; MemWrite = mw; DataAdr = a; WriteData = d;
    @(posedge clk);
    model_edge(e, mw, a, d);
    @(negedge clk);
  endtask

  task automatic test_reset();
    model_clear();
    #12;
    vectors++;
    if (obs !== '0) begin
      miscompares++;
      $display("FAIL reset_hold: got %h want 0", obs);
    end
    #10 reset = 1'b1;
    @(negedge clk);
    drive(1'b0, 1'b0, '0, '0);
    vectors++;
    if (obs !== exp_vec()) begin
      miscompares++;
      $display("FAIL reset_idle: got %h want %h", obs, exp_vec());
    end
  endtask

  task automatic test_pass();
    drive(1'b1, 1'b1, 32'd100, 32'd24);
    vectors++;
    if (obs !== exp_vec() || done !== 1'b0 || write_count !== 16'd0) begin
      miscompares++;
      $display("FAIL arm_ignores_store: got %h want %h", obs, exp_vec());
    end
    drive(1'b1, 1'b1, 32'd96, 32'd7);
    drive(1'b1, 1'b1, 32'd100, 32'd25);
    vectors++;
    if (pass !== 1'b1 || fail !== 1'b0 || write_count !== 16'd2 || fail_code !== 2'd0) begin
      miscompares++;
      $display("FAIL pass_basic: got p=%b f=%b wc=%0d code=%0d want p=1 f=0 wc=2 code=0",
               pass, fail, write_count, fail_code);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 32'h40, 32'd5);
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++;
        $display("FAIL pass_sticky cyc%0d: got %h want %h", i, obs, exp_vec());
      end
    end
  endtask

  task automatic test_rearm();
    drive(1'b0, 1'b0, '0, '0);
    vectors++;
    if (obs !== '0) begin
      miscompares++;
      $display("FAIL rearm_clear: got %h want 0", obs);
    end
    drive(1'b1, 1'b0, '0, '0);
    drive(1'b1, 1'b1, 32'd100, 32'd25);
    vectors++;
    if (pass !== 1'b1 || write_count !== 16'd1 || obs !== exp_vec()) begin
      miscompares++;
      $display("FAIL rearm_pass: got %h want %h", obs, exp_vec());
    end
  endtask

  task automatic test_bad_data();
    drive(1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, '0, '0);
    drive(1'b1, 1'b1, 32'd100, 32'd24);
    vectors++;
    if (fail !== 1'b1 || fail_code !== 2'd2 || fail_adr !== 32'd100 || fail_data !== 32'd24) begin
      miscompares++;
      $display("FAIL bad_data: got f=%b code=%0d adr=%0d data=%0d want f=1 code=2 adr=100 data=24",
               fail, fail_code, fail_adr, fail_data);
    end
  endtask

  task automatic test_bad_adr();
    drive(1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, '0, '0);
    drive(1'b1, 1'b1, 32'd96, 32'd1);
    drive(1'b1, 1'b1, 32'h40, 32'd5);
    vectors++;
    if (fail_code !== 2'd1 || fail_adr !== 32'h40 || fail_data !== 32'd5 || write_count !== 16'd2) begin
      miscompares++;
      $display("FAIL bad_adr: got code=%0d adr=%h data=%0d wc=%0d want code=1 adr=40 data=5 wc=2",
               fail_code, fail_adr, fail_data, write_count);
    end
  endtask

  task automatic test_en_beats_store();
    drive(1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, '0, '0);
    drive(1'b1, 1'b1, 32'd97, 32'd3);
    drive(1'b0, 1'b1, 32'd100, 32'd25);
    vectors++;
    if (obs !== '0 || obs !== exp_vec()) begin
      miscompares++;
      $display("FAIL en_beats_store: got %h want 0", obs);
    end
  endtask

  task automatic test_timeout();
    int n;
    n = TO_EN ? 70 : 200;
    drive(1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, '0, '0);
    for (int i = 1; i <= n; i++) begin
      drive(1'b1, 1'b0, 32'bx, 32'bx);
      vectors++;
      if (obs !== exp_vec() || done !== (TO_EN && i >= TO)) begin
        miscompares++;
        $display("FAIL timeout cyc%0d: got %h want %h", i, obs, exp_vec());
      end
    end
    vectors++;
    if (TO_EN) begin
      if (fail_code !== 2'd3 || cycle_count !== 16'd64 || fail_adr !== '0 || fail_data !== '0) begin
        miscompares++;
        $display("FAIL timeout_final: got code=%0d cc=%0d adr=%0d data=%0d want code=3 cc=64 adr=0 data=0",
                 fail_code, cycle_count, fail_adr, fail_data);
      end
    end else if (done !== 1'b0 || cycle_count !== 16'd200) begin
      miscompares++;
      $display("FAIL no_timeout: got done=%b cc=%0d want done=0 cc=200", done, cycle_count);
    end
  endtask

  task automatic test_async_reset();
    drive(1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, '0, '0);
    drive(1'b1, 1'b1, 32'd98, 32'd9);
    drive(1'b1, 1'b0, '0, '0);
    #2 reset = 1'b0;
    model_clear();
    #1;
    vectors++;
    if (obs !== '0) begin
      miscompares++;
      $display("FAIL async_reset: got %h want 0", obs);
    end
    @(negedge clk);
    reset = 1'b1;
    drive(1'b0, 1'b0, '0, '0);
    vectors++;
    if (obs !== exp_vec()) begin
      miscompares++;
      $display("FAIL async_reset_idle: got %h want %h", obs, exp_vec());
    end
  endtask

  task automatic test_random();
    int kind;
    logic e, mw;
    logic [31:0] a, d;
    for (int r = 0; r < 8; r++) begin
      drive(1'b0, 1'b0, '0, '0);
      for (int i = 0; i < 40; i++) begin
        e = ($urandom_range(0, 29) != 0);
        kind = $urandom_range(0, 9);
        mw = 1'b1;
        a = 32'($urandom_range(96, 99));
        d = $urandom;
        if (kind < 5) begin
          mw = 1'b0;
          a = ($urandom_range(0, 1) != 0) ? 32'bx : 32'd100;
        end else if (kind == 8) begin
          a = 32'd100;
          d = ($urandom_range(0, 1) != 0) ? 32'd25 : 32'($urandom_range(0, 30));
        end else if (kind == 9) begin
          a = 32'($urandom_range(0, 127));
        end
        drive(e, mw, a, d);
        vectors++;
        if (obs !== exp_vec()) begin
          miscompares++;
          $display("FAIL random r%0d cyc%0d: got %h want %h", r, i, obs, exp_vec());
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_rearm();
    test_bad_data();
    test_bad_adr();
    test_en_beats_store();
    test_timeout();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
